tile_line_buffer: RTL and testbench

TILE_LINE_BUFFER -- requirements
Module: tile_line_buffer

---
 rtl/tile_line_buffer.sv | 131 +++++++++++++
 tb/tb_tile_line_buffer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/tile_line_buffer.sv
// Line buffer of N+S channel-planar lines that emits NxN tiles per channel at stride S; build with TILE_LB_EDGE_PAD_EN for zero-padded right-edge tiles.
// Latency: a pixel accepted in cycle t is visible in o_tile at t+1; o_tile_valid rises the cycle after the N-th line completes.
// Backpressure: o_ready drops while all line slots are full; o_tile is held stable while o_tile_valid && !i_tile_ready.
module tile_line_buffer #(
    parameter int M  = 3,
    parameter int W  = 512,
    parameter int N  = 4,
    parameter int S  = 2,
    parameter int DW = 8,
    localparam int ROWS = N + S
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [DW-1:0]               i_data,
    input  logic                        i_data_valid,
    output logic                        o_ready,
    output logic [M*N*N*DW-1:0]         o_tile,
    output logic                        o_tile_valid,
    input  logic                        i_tile_ready,
    output logic [$clog2(ROWS+1)-1:0]   o_lines
);

    localparam int LINE = M * W;
    localparam int IW   = (LINE > 1) ? $clog2(LINE) : 1;
    localparam int SW   = $clog2(ROWS);
    localparam int LW   = $clog2(ROWS + 1);
    localparam int CW   = (W > 1) ? $clog2(W) : 1;
`ifdef TILE_LB_EDGE_PAD_EN
    localparam int LAST_COL = ((W - N + S - 1) / S) * S;
`else
    localparam int LAST_COL = ((W - N) / S) * S;
`endif

    typedef enum logic {FILL, STREAM} state_t;

    state_t         state, state_d;
    logic [DW-1:0]  mem [ROWS][LINE];
    logic [IW-1:0]  wr_idx;
    logic [SW-1:0]  wr_slot;
    logic [SW-1:0]  rd_base;
    logic [CW-1:0]  rd_col;
    logic [LW-1:0]  lines_d;
    logic           accept, line_done, tile_hs, rows_free;

    // Slot indices wrap mod ROWS, which need not be a power of two.
    function automatic logic [SW-1:0] wrap_add(input logic [SW-1:0] a, input int unsigned b);
        logic [SW:0] s;
        s = {1'b0, a} + (SW+1)'(b);
        if (s >= (SW+1)'(ROWS))
            s = s - (SW+1)'(ROWS);
        return s[SW-1:0];
    endfunction

    assign o_ready   = (o_lines < LW'(ROWS));
    assign accept    = i_data_valid && o_ready;
    assign line_done = accept && (wr_idx == IW'(LINE - 1));
    assign tile_hs   = o_tile_valid && i_tile_ready;
    assign rows_free = tile_hs && (rd_col == CW'(LAST_COL));

    always_comb begin
        lines_d      = o_lines;
        state_d      = state;
        o_tile_valid = 1'b0;
        if (line_done)
            lines_d = lines_d + LW'(1);
        if (rows_free)
            lines_d = lines_d - LW'(S);
        // Next state follows the next line count so valid drops the same edge rows are released.
        case (state)
            FILL:    if (lines_d >= LW'(N)) state_d = STREAM;
            STREAM:  if (lines_d <  LW'(N)) state_d = FILL;
            default: state_d = FILL;
        endcase
        o_tile_valid = (state == STREAM);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= FILL;
            o_lines <= '0;
            wr_idx  <= '0;
            wr_slot <= '0;
            rd_base <= '0;
            rd_col  <= '0;
        end else begin
            state   <= state_d;
            o_lines <= lines_d;
            if (accept) begin
                if (line_done) begin
                    wr_idx  <= '0;
                    wr_slot <= wrap_add(wr_slot, 1);
                end else begin
                    wr_idx  <= wr_idx + IW'(1);
                end
            end
            if (tile_hs) begin
                if (rows_free) begin
                    rd_col  <= '0;
                    rd_base <= wrap_add(rd_base, S);
                end else begin
                    rd_col  <= rd_col + CW'(S);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (accept && !i_rst)
            mem[wr_slot][wr_idx] <= i_data;
    end

    for (genvar r = 0; r < N; r++) begin : g_row
        logic [SW-1:0] slot;
        assign slot = wrap_add(rd_base, r);
        for (genvar c = 0; c < M; c++) begin : g_ch
            for (genvar k = 0; k < N; k++) begin : g_px
                logic [CW:0]   col;
                logic [IW-1:0] addr;
                assign col  = {1'b0, rd_col} + (CW+1)'(k);
                assign addr = IW'(c * W) + IW'(col);
`ifdef TILE_LB_EDGE_PAD_EN
                assign o_tile[((M*N*N-1)-(c*N*N+r*N+k))*DW +: DW] =
                    (col >= (CW+1)'(W)) ? '0 : mem[slot][addr];
`else
                assign o_tile[((M*N*N-1)-(c*N*N+r*N+k))*DW +: DW] = mem[slot][addr];
`endif
            end
        end
    end

endmodule

// File: tb/tb_tile_line_buffer.sv
// Directed bench for tile_line_buffer at M=1,N=4,S=2,DW=8 with W=8 and a second W=9 instance for the right edge.
module tb_tile_line_buffer;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [7:0]   d;
    logic         dv, rdy, tv, tr;
    logic [127:0] tile;
    logic [2:0]   lines;

    logic [7:0]   d9;
    logic         dv9, rdy9, tv9, tr9;
    logic [127:0] tile9;
    logic [2:0]   lines9;

    int n_chk  = 0;
    int n_pass = 0;

    tile_line_buffer #(.M(1), .W(8), .N(4), .S(2), .DW(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_data(d), .i_data_valid(dv), .o_ready(rdy),
        .o_tile(tile), .o_tile_valid(tv), .i_tile_ready(tr), .o_lines(lines)
    );

    tile_line_buffer #(.M(1), .W(9), .N(4), .S(2), .DW(8)) dut9 (
        .i_clk(clk), .i_rst(rst), .i_data(d9), .i_data_valid(dv9), .o_ready(rdy9),
        .o_tile(tile9), .o_tile_valid(tv9), .i_tile_ready(tr9), .o_lines(lines9)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_chk++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    endtask

    // Tile element (r,k) = pixel of line row0+r at column col0+k; columns past the line read as zero.
    function automatic logic [127:0] exp_tile(input int row0, input int col0, input int base, input int w);
        logic [127:0] v;
        v = '0;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++)
                v[(15-(r*4+k))*8 +: 8] = ((col0 + k) >= w) ? 8'h00 : 8'(base + (row0 + r)*16 + col0 + k);
        return v;
    endfunction

    task automatic push(input int row, input int base);
        for (int c = 0; c < 8; c++) begin
            d  = 8'(base + row*16 + c);
            dv = 1'b1;
            @(posedge clk); #1;
        end
        dv = 1'b0;
    endtask

    task automatic push9(input int row);
        for (int c = 0; c < 9; c++) begin
            d9  = 8'(row*16 + c);
            dv9 = 1'b1;
            @(posedge clk); #1;
        end
        dv9 = 1'b0;
    endtask

    initial begin
        rst = 1'b1; d = '0; dv = 1'b0; tr = 1'b0;
        d9 = '0; dv9 = 1'b0; tr9 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_lines", 128'(lines), 128'd0);
        chk("rst_valid", 128'(tv), 128'd0);
        chk("rst_ready", 128'(rdy), 128'd1);
        rst = 1'b0;

        // Fill
        push(0, 0); push(1, 0); push(2, 0);
        chk("fill3_lines", 128'(lines), 128'd3);
        chk("fill3_valid", 128'(tv), 128'd0);
        push(3, 0);
        chk("fill4_valid", 128'(tv), 128'd1);
        chk("fill4_lines", 128'(lines), 128'd4);
        chk("fill4_tile", tile, exp_tile(0, 0, 0, 8));

        // Stride across start columns 0,2,4
        tr = 1'b1;
        @(posedge clk); #1;
        chk("stride_col2", tile, exp_tile(0, 2, 0, 8));
        @(posedge clk); #1;
        chk("stride_col4", tile, exp_tile(0, 4, 0, 8));
        @(posedge clk); #1;
        tr = 1'b0;
        chk("stride_lines", 128'(lines), 128'd2);
        chk("stride_valid", 128'(tv), 128'd0);
        push(4, 0); push(5, 0);
        chk("resume_valid", 128'(tv), 128'd1);
        chk("resume_tile", tile, exp_tile(2, 0, 0, 8));

        // Backpressure with all slots full
        push(6, 0); push(7, 0);
        chk("bp_lines", 128'(lines), 128'd6);
        chk("bp_ready", 128'(rdy), 128'd0);
        for (int i = 0; i < 10; i++) begin
            d  = 8'hFF;
            dv = 1'b1;
            @(posedge clk); #1;
            chk("bp_tile_hold", tile, exp_tile(2, 0, 0, 8));
        end
        dv = 1'b0;
        chk("bp_lines_after", 128'(lines), 128'd6);
        chk("bp_valid_after", 128'(tv), 128'd1);

        // Drain one row group, then line completion coincident with row release
        tr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        tr = 1'b0;
        chk("drain_lines", 128'(lines), 128'd4);
        chk("drain_tile", tile, exp_tile(4, 0, 0, 8));
        push(8, 0);
        chk("l8_lines", 128'(lines), 128'd5);
        for (int c = 0; c < 8; c++) begin
            d  = 8'(9*16 + c);
            dv = 1'b1;
            tr = (c >= 5);
            if (c == 7) chk("sim_lines_before", 128'(lines), 128'd5);
            @(posedge clk); #1;
        end
        dv = 1'b0; tr = 1'b0;
        chk("sim_lines_after", 128'(lines), 128'd4);
        chk("sim_valid", 128'(tv), 128'd1);
        chk("sim_tile", tile, exp_tile(6, 0, 0, 8));

        // Reset after 2.5 lines
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        push(0, 8'h40); push(1, 8'h40);
        for (int c = 0; c < 4; c++) begin
            d  = 8'(8'h40 + 2*16 + c);
            dv = 1'b1;
            @(posedge clk); #1;
        end
        dv = 1'b0;
        chk("mid_lines", 128'(lines), 128'd2);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mrst_lines", 128'(lines), 128'd0);
        chk("mrst_valid", 128'(tv), 128'd0);
        chk("mrst_ready", 128'(rdy), 128'd1);
        rst = 1'b0;
        push(0, 8'h80); push(1, 8'h80); push(2, 8'h80); push(3, 8'h80);
        chk("fresh_valid", 128'(tv), 128'd1);
        chk("fresh_tile", tile, exp_tile(0, 0, 8'h80, 8));

        // Right edge with W=9
        push9(0); push9(1); push9(2); push9(3);
        chk("w9_lines", 128'(lines9), 128'd4);
        chk("w9_tile0", tile9, exp_tile(0, 0, 0, 9));
        tr9 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("w9_tile4", tile9, exp_tile(0, 4, 0, 9));
`ifdef TILE_LB_EDGE_PAD_EN
        @(posedge clk); #1;
        chk("w9_tile6_pad", tile9, exp_tile(0, 6, 0, 9));
        chk("w9_tile6_valid", 128'(tv9), 128'd1);
`endif
        @(posedge clk); #1;
        tr9 = 1'b0;
        chk("w9_lines_after", 128'(lines9), 128'd2);
        chk("w9_valid_after", 128'(tv9), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
